// File: rtl/axis_m_pkt.sv
// Internal ready/valid source to AXI4-Stream master adapter.
// Frames packets by programmable beat count or early last_in, drives AXIS from a 2-entry skid.
module axis_m_pkt #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LEN_W = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             last_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [CNT_W-1:0] pkt_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} skid_e;

  skid_e            state_q, state_d;
  logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic             last0_q, last0_d, last1_q, last1_d;
  logic             valid_q, valid_d, ready_q, ready_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, eff_len;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic             accept, emit, beat_last;

  assign accept = valid_in & ready_q;
  assign emit   = valid_q & m_axis_tready;

  // Framing: length is latched on the first beat so mid-packet pkt_len changes are ignored.
  always_comb begin
    cnt_d     = cnt_q;
    len_d     = len_q;
    eff_len   = (cnt_q == '0) ? pkt_len : len_q;
    beat_last = last_in | ((eff_len != '0) & (cnt_q == eff_len - LEN_W'(1)));
    if (accept) begin
      if (cnt_q == '0) begin
        len_d = pkt_len;
      end
      if (beat_last) begin
        cnt_d = '0;
      end else if (!(&cnt_q)) begin
        cnt_d = cnt_q + LEN_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data0_d = data0_q;
    last0_d = last0_q;
    data1_d = data1_q;
    last1_d = last1_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          data0_d = data_in;
          last0_d = beat_last;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && emit) begin
          data0_d = data_in;
          last0_d = beat_last;
        end else if (accept) begin
          data1_d = data_in;
          last1_d = beat_last;
          state_d = StFull;
        end else if (emit) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (emit) begin
          data0_d = data1_q;
          last0_d = last1_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    valid_d = (state_d != StEmpty);
    ready_d = (state_d != StFull);
  end

  always_comb begin
    pkt_d = pkt_q;
    if (emit && last0_q) begin
      pkt_d = pkt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data0_q <= '0;
      last0_q <= 1'b0;
      data1_q <= '0;
      last1_q <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      data0_q <= data0_d;
      last0_q <= last0_d;
      data1_q <= data1_d;
      last1_q <= last1_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pkt_q   <= pkt_d;
    end
  end

  assign ready_out     = ready_q;
  assign m_axis_tdata  = data0_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last0_q;
  assign pkt_count     = pkt_q;

endmodule

// File: tb/tb_axis_m_pkt.sv
// Self-checking bench for axis_m_pkt: packet-level queue model compared every negedge,
// plus literal expectations on tlast positions and packet counts.
module tb_axis_m_pkt;

  logic        clk;
  logic        rst_n;
  logic [15:0] pkt_len;
  logic        valid_in;
  logic [31:0] data_in;
  logic        last_in;
  logic        ready_out;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [15:0] pkt_count;

  axis_m_pkt #(.WIDTH(32), .LEN_W(16), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pkt_len      (pkt_len),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .last_in      (last_in),
    .ready_out    (ready_out),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .pkt_count    (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of beats between accept and emit, plus packet position bookkeeping.
  typedef struct packed {logic last; logic [31:0] data;} beat_t;
  beat_t       q[$];
  logic [31:0] last_log[$];
  logic [31:0] exp_l[$];
  int          m_pos;
  int          m_len;
  logic [15:0] m_pkts;
  bit          armed;

  always @(negedge clk) begin
    bit    exp_ready, exp_valid, emit, acc, is_last;
    int    len_now;
    beat_t b;
    if (!rst_n) begin
      chk("rst_ready", ready_out, 0);
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_pkt_count", pkt_count, 0);
      q.delete();
      m_pos = 0;
      m_len = 0;
      m_pkts = 0;
      armed = 0;
    end else begin
      exp_ready = armed && (q.size() < 2);
      exp_valid = (q.size() > 0);
      chk("ready_out", ready_out, exp_ready);
      chk("tvalid", m_axis_tvalid, exp_valid);
      chk("pkt_count", pkt_count, m_pkts);
      if (exp_valid) begin
        chk("tdata", m_axis_tdata, q[0].data);
        chk("tlast", m_axis_tlast, q[0].last);
      end
      emit = exp_valid && m_axis_tready;
      acc  = exp_ready && valid_in;
      if (emit) begin
        b = q.pop_front();
        if (b.last) begin
          m_pkts++;
          last_log.push_back(b.data);
        end
      end
      if (acc) begin
        if (m_pos == 0) m_len = int'(pkt_len);
        len_now = m_len;
        is_last = last_in || (len_now != 0 && m_pos + 1 == len_now);
        q.push_back('{last: is_last, data: data_in});
        m_pos = is_last ? 0 : m_pos + 1;
      end
      armed = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l, input logic [15:0] len);
    bit got;
    int tries;
    valid_in = 1'b1;
    data_in  = d;
    last_in  = l;
    pkt_len  = len;
    tries    = 0;
    forever begin
      got = ready_out;
      step();
      if (got) break;
      tries++;
      if (tries > 50) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic check_lasts(input string name);
    chk({name, "_nlast"}, last_log.size(), exp_l.size());
    for (int i = 0; i < exp_l.size() && i < last_log.size(); i++) begin
      chk({name, "_last"}, last_log[i], exp_l[i]);
    end
    last_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit got;
    rst_n = 1'b0;
    pkt_len = 16'd4;
    valid_in = 1'b0;
    data_in = '0;
    last_in = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // 1: fixed length 4, 12 back-to-back beats
    for (int i = 0; i < 12; i++) send_beat(32'(i), 1'b0, 16'd4);
    repeat (4) step();
    exp_l = '{32'd3, 32'd7, 32'd11};
    check_lasts("t1");
    chk("t1_pkt_count", pkt_count, 16'd3);

    // 2: early last on beat 1, then a fresh 4-beat packet
    send_beat(32'hA0, 1'b0, 16'd4);
    send_beat(32'hA1, 1'b1, 16'd4);
    repeat (3) step();
    chk("t2_pkt_count_early", pkt_count, 16'd4);
    for (int i = 0; i < 4; i++) send_beat(32'hB0 + 32'(i), 1'b0, 16'd4);
    repeat (4) step();
    exp_l = '{32'hA1, 32'hB3};
    check_lasts("t2");
    chk("t2_pkt_count", pkt_count, 16'd5);

    // 3: backpressure fills the skid after exactly two beats
    m_axis_tready = 1'b0;
    acc = 0;
    pkt_len = 16'd4;
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1;
      data_in  = 32'h30 + 32'(acc);
      got      = ready_out;
      step();
      if (got) acc++;
    end
    valid_in = 1'b0;
    chk("t3_accepted", acc, 2);
    chk("t3_ready_low", ready_out, 0);
    chk("t3_tdata_held", m_axis_tdata, 32'h30);
    m_axis_tready = 1'b1;
    repeat (4) step();
    send_beat(32'h32, 1'b0, 16'd4);
    send_beat(32'h33, 1'b0, 16'd4);
    repeat (4) step();
    exp_l = '{32'h33};
    check_lasts("t3");
    chk("t3_pkt_count", pkt_count, 16'd6);

    // 4: unbounded length ends only on last_in; length 1 makes every beat last
    for (int i = 0; i < 10; i++) send_beat(32'h40 + 32'(i), (i == 9), 16'd0);
    for (int i = 0; i < 3; i++) send_beat(32'h50 + 32'(i), 1'b0, 16'd1);
    repeat (4) step();
    exp_l = '{32'h49, 32'h50, 32'h51, 32'h52};
    check_lasts("t4");
    chk("t4_pkt_count", pkt_count, 16'd10);

    // 5: pkt_len change mid-packet only affects the next packet
    send_beat(32'h60, 1'b0, 16'd4);
    for (int i = 1; i < 6; i++) send_beat(32'h60 + 32'(i), 1'b0, 16'd2);
    repeat (4) step();
    exp_l = '{32'h63, 32'h65};
    check_lasts("t5");
    chk("t5_pkt_count", pkt_count, 16'd12);

    // 6: reset with skid full mid-packet
    m_axis_tready = 1'b0;
    send_beat(32'h6A, 1'b0, 16'd4);
    send_beat(32'h6B, 1'b0, 16'd4);
    chk("t6_full_ready", ready_out, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", m_axis_tvalid, 0);
    chk("t6_rst_ready", ready_out, 0);
    chk("t6_rst_pkt_count", pkt_count, 0);
    repeat (2) step();
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    last_log.delete();
    step();
    for (int i = 0; i < 4; i++) send_beat(32'h70 + 32'(i), 1'b0, 16'd4);
    repeat (4) step();
    exp_l = '{32'h73};
    check_lasts("t6");
    chk("t6_pkt_count", pkt_count, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
